// File: rtl/mem_arbiter.sv
// Two-master single-port RAM arbiter with bounded bursts.
// Grants are combinational; read returns are tagged one cycle later.
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_re,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_re,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] rdata,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_re,
  output logic [3:0]  ram_we,
  input  logic [31:0] ram_rdata
);

  localparam logic [3:0] LP_MAX = 4'(MAX_BURST);

  logic       w_req0;
  logic       w_req1;
  logic       w_keep;
  logic       w_pick1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_last_nxt;
  logic [3:0] w_cnt_nxt;
  logic       r_last;
  logic [3:0] r_cnt;
  logic [1:0] r_rtag;

  assign w_req0 = m0_re | (|m0_we);
  assign w_req1 = m1_re | (|m1_we);

  // On a tie, stay with last only mid-burst; an idle gap hands over.
  assign w_keep  = (r_cnt != 4'd0) && (r_cnt < LP_MAX);
  assign w_pick1 = w_keep ? r_last : ~r_last;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      unique case ({w_req1, w_req0})
        2'b01: w_gnt0 = 1'b1;
        2'b10: w_gnt1 = 1'b1;
        2'b11: begin
          w_gnt1 = w_pick1;
          w_gnt0 = ~w_pick1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    w_cnt_nxt  = 4'd0;
    if (w_gnt0 | w_gnt1) begin
      w_last_nxt = w_gnt1;
      if (w_gnt1 == r_last)
        w_cnt_nxt = (r_cnt < LP_MAX) ? r_cnt + 4'd1 : r_cnt;
      else
        w_cnt_nxt = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
      r_cnt  <= 4'd0;
      r_rtag <= 2'b00;
    end else begin
      r_last <= w_last_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rtag <= {w_gnt1 & m1_re, w_gnt0 & m0_re};
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rtag[0] & reset;
  assign m1_rvalid = r_rtag[1] & reset;
  assign rdata     = ram_rdata;

  assign ram_addr  = w_gnt1 ? m1_addr : m0_addr;
  assign ram_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  assign ram_re    = (w_gnt0 & m0_re) | (w_gnt1 & m1_re);
  assign ram_we    = ({4{w_gnt0}} & m0_we) | ({4{w_gnt1}} & m1_we);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, behavioural arbitration
// model with per-cycle compare, directed scenarios, random traffic.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk;
  logic        reset;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_re, m1_re;
  logic [3:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic [29:0] ram_addr;
  logic        ram_re;
  logic [3:0]  ram_we;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_re(m0_re),
    .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_re(m1_re),
    .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram  [32];
  logic [31:0] emem [32];
  logic [31:0] imem [32];

  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram[ram_addr[4:0]];
    for (int b = 0; b < 4; b++)
      if (ram_we[b])
        ram[ram_addr[4:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: winner history, pending read, expected memory
  int          last_m = 1;
  int          hist[$];
  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [31:0] pdata = '0;
  logic        mg0 = 1'b0, mg1 = 1'b0;

  always @(negedge clk) begin
    logic r0, r1, ev0, ev1, xre;
    int s, sel;
    logic [3:0]  xwe;
    logic [29:0] xa;
    logic [31:0] xd;
    ev0 = pend0 && reset;
    ev1 = pend1 && reset;
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
    if (ev0 || ev1) chk("rdata", rdata, pdata);
    if (!reset) begin
      pend0 = 0; pend1 = 0; mg0 = 0; mg1 = 0;
      last_m = 1;
      hist.delete();
      chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
      chk("rst_ram", 32'({ram_re, ram_we}), 32'd0);
    end else begin
      r0 = m0_re || (m0_we != 0);
      r1 = m1_re || (m1_we != 0);
      s = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != last_m) break;
        s++;
      end
      sel = -1;
      if (r0 && !r1) sel = 0;
      else if (r1 && !r0) sel = 1;
      else if (r0 && r1)
        sel = (s > 0 && s < MAXB) ? last_m : 1 - last_m;
      mg0 = (sel == 0);
      mg1 = (sel == 1);
      xre = (sel == 0) ? m0_re : (sel == 1) ? m1_re : 1'b0;
      xwe = (sel == 0) ? m0_we : (sel == 1) ? m1_we : 4'd0;
      xa  = (sel == 1) ? m1_addr : m0_addr;
      xd  = (sel == 1) ? m1_wdata : m0_wdata;
      chk("m0_gnt", 32'(m0_gnt), 32'(mg0));
      chk("m1_gnt", 32'(m1_gnt), 32'(mg1));
      chk("ram_re", 32'(ram_re), 32'(xre));
      chk("ram_we", 32'(ram_we), 32'(xwe));
      if (sel >= 0) chk("ram_addr", 32'(ram_addr), 32'(xa));
      if (xwe != 0) chk("ram_wdata", ram_wdata, xd);
      if (sel < 0) hist.delete();
      else begin
        if (sel != last_m) hist.delete();
        hist.push_back(sel);
        last_m = sel;
        if (hist.size() > 16) void'(hist.pop_front());
      end
      pend0 = mg0 && m0_re;
      pend1 = mg1 && m1_re;
      pdata = emem[xa[4:0]];
      for (int b = 0; b < 4; b++)
        if (xwe[b]) emem[xa[4:0]][8*b +: 8] = xd[8*b +: 8];
    end
  end

  task automatic set_req(input int m, input int k);
    int kk, r;
    logic re;
    logic [3:0] we;
    logic [29:0] a;
    logic [31:0] d;
    kk = k;
    if (k == 4) begin
      r = int'($urandom_range(0, 5));
      kk = (r == 0) ? 0 : (r < 3) ? 1 : (r < 5) ? 2 : 3;
    end
    a  = 30'($urandom_range(0, 31));
    d  = $urandom;
    re = (kk == 1) || (kk == 3);
    we = ((kk == 2) || (kk == 3)) ? 4'($urandom_range(1, 15)) : 4'd0;
    if (m == 0) begin
      m0_re = re; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_re = re; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Masters only change their request once it has been granted
  task automatic step(input int k0, input int k1);
    @(posedge clk); #1;
    if (mg0 || !(m0_re || (m0_we != 0))) set_req(0, k0);
    if (mg1 || !(m1_re || (m1_we != 0))) set_req(1, k1);
  endtask

  initial begin
    int pat [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int got;
    for (int i = 0; i < 32; i++) begin
      imem[i] = $urandom;
      ram[i]  = imem[i];
      emem[i] = imem[i];
    end
    reset = 1'b0;
    set_req(0, 0);
    set_req(1, 0);
    ram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1); m0_addr = 30'd3;
    set_req(1, 1); m1_addr = 30'd5;
    @(negedge clk);
    chk("lit_rst_nogrant", 32'({m1_gnt, m0_gnt}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("lit_first_m0", 32'({m1_gnt, m0_gnt}), 32'b01);
    chk("lit_first_addr", 32'(ram_addr), 32'd3);
    for (int i = 1; i < 10; i++) begin
      step(1, 1);
      @(negedge clk);
      if (i == 1) begin
        chk("lit_first_rvalid", 32'(m0_rvalid), 32'd1);
        chk("lit_first_rdata", rdata, imem[3]);
      end
      got = m1_gnt ? 1 : m0_gnt ? 0 : 2;
      chk("lit_burst_pat", 32'(got), 32'(pat[i]));
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1);
      @(negedge clk);
      chk("lit_m1_alone", 32'({m1_gnt, m0_gnt}), 32'b10);
    end
    step(1, 1);
    @(negedge clk);
    chk("lit_m0_after_sat", 32'({m1_gnt, m0_gnt}), 32'b01);
    repeat (3) step(0, 0);
    step(0, 2);
    m1_addr = 30'h10; m1_wdata = 32'hDEADBEEF; m1_we = 4'hF;
    step(1, 0);
    m0_addr = 30'h10;
    @(negedge clk);
    chk("lit_raw_gnt", 32'(m0_gnt), 32'd1);
    step(0, 0);
    @(negedge clk);
    chk("lit_raw_rvalid", 32'(m0_rvalid), 32'd1);
    chk("lit_raw_rdata", rdata, 32'hDEADBEEF);
    step(0, 0);
    step(1, 0);
    m0_addr = 30'd7;
    @(negedge clk);
    chk("lit_pre_rst_gnt", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    m1_re = 1'b0; m1_we = 4'hF; m1_addr = 30'd9;
    @(negedge clk);
    chk("lit_midrst_rvalid", 32'(m0_rvalid), 32'd0);
    chk("lit_midrst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    chk("lit_midrst_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_tie", 32'({m1_gnt, m0_gnt}), 32'b01);
    chk("lit_post_rst_rv", 32'(m0_rvalid), 32'd0);
    repeat (3) step(0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0);
      @(negedge clk);
      if (i > 0) chk("lit_alt_m1_rv", 32'(m1_rvalid), 32'd1);
      step(0, 1);
      @(negedge clk);
      chk("lit_alt_m0_rv", 32'(m0_rvalid), 32'd1);
    end
    for (int i = 0; i < 3000; i++) begin
      step(4, 4);
      reset = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
